// File: rtl/rr_arbiter_hold_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_hold_if
//  Description : Request/hold/grant bundle between requesters (master side)
//                and the round-robin arbiter (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter_hold_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  hold;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;

    modport master (
        output req,
        output hold,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  req,
        input  hold,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_hold
//  Description : N-way round-robin arbiter with a registered one-hot grant and
//                a per-requester hold that lets the current owner keep the
//                grant for multi-beat transfers.
//                Optional macro RR_ARB_HOLD_TIMEOUT_EN bounds each tenure to
//                MAX_HOLD cycles; without it a holder may keep the grant
//                indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_hold #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rr_arbiter_hold_if.slave   bus
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  r_grant;
    logic [IW-1:0] r_grant_idx;
    logic          r_grant_valid;
    logic [IW-1:0] r_ptr;

    logic          w_found;
    logic [IW-1:0] w_next_idx;
    logic [N-1:0]  w_onehot;
    logic          w_timeout;
    logic          w_keep;

    // (base + offs) mod N, valid for base < N and offs <= N
    function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int offs);
        int v_sum;
        v_sum = int'(base) + offs;
        if (v_sum >= N) begin
            v_sum = v_sum - N;
        end
        return v_sum[IW-1:0];
    endfunction

    // Search requests starting just after the last winner; the last winner
    // itself is visited last, so it has the lowest priority.
    always_comb begin
        w_found    = 1'b0;
        w_next_idx = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && bus.req[f_wrap(r_ptr, k)]) begin
                w_found    = 1'b1;
                w_next_idx = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_next_idx;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] r_hold_cnt;

    // The last permitted cycle of a tenure is when the counter reaches MAX_HOLD-1
    assign w_timeout = (r_hold_cnt == HW'(MAX_HOLD - 1));

    // Count cycles of the current tenure; restarts on every fresh grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (w_keep) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end else if (w_found) begin
            r_hold_cnt <= '0;
        end
    end
`else
    // Tenure is unbounded in this build; MAX_HOLD only has a legality role
    assign w_timeout = (MAX_HOLD < 1) & 1'b0;
`endif

    // Holder keeps the grant only while still requesting and asking to hold
    assign w_keep = r_grant_valid & bus.req[r_grant_idx] & bus.hold[r_grant_idx] & ~w_timeout;

    // Grant, index, valid and pointer update together each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= IW'(N - 1);
        end else if (w_keep) begin
            r_grant       <= r_grant;
            r_grant_idx   <= r_grant_idx;
            r_grant_valid <= 1'b1;
        end else if (w_found) begin
            r_grant       <= w_onehot;
            r_grant_idx   <= w_next_idx;
            r_grant_valid <= 1'b1;
            r_ptr         <= w_next_idx;
        end else begin
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_idx   = r_grant_idx;
    assign bus.grant_valid = r_grant_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_hold
//  Description : Directed self-checking bench for rr_arbiter_hold with N=4,
//                MAX_HOLD=4. Expectations follow RR_ARB_HOLD_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_hold;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rr_arbiter_hold_if #(.N(N)) bus ();

    rr_arbiter_hold #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic v);
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        check({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
        check({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.hold = 4'b0000;
        step();
        step();
        check_grant("reset", 4'b0000, 2'd0, 1'b0);

        // Full rotation from reset: 0,1,2,3,0,1,2,3
        rst     = 1'b0;
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check_grant("rotate", 4'b0001 << (i % 4), 2'(i % 4), 1'b1);
        end

        // Sparse rotation; hold bits on never-granted requesters are inert
        bus.req  = 4'b0101;
        bus.hold = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("sparse", 32'(bus.grant), (i % 2 == 0) ? 32'h1 : 32'h4);
        end

        // ptr=2: 1111 gives 3, 0, then 1
        bus.req  = 4'b1111;
        bus.hold = 4'b0000;
        step();
        check("pre_hold_a", 32'(bus.grant), 32'h8);
        step();
        check("pre_hold_b", 32'(bus.grant), 32'h1);
        step();
        check_grant("hold_start", 4'b0010, 2'd1, 1'b1);

        bus.hold = 4'b0010;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            step();
            check("hold_to", 32'(bus.grant), (i < 4) ? 32'h2 : 32'h4);
        end
`else
        for (int i = 1; i <= 20; i++) begin
            step();
            check("hold_inf", 32'(bus.grant), 32'h2);
        end
`endif

        // Bring both builds to grant=0100
        bus.hold = 4'b0000;
        bus.req  = 4'b0100;
        step();
        check("drop_setup", 32'(bus.grant), 32'h4);

        // Holder drops req: hold is ignored and 3 wins
        bus.hold = 4'b0100;
        bus.req  = 4'b1000;
        step();
        check_grant("drop", 4'b1000, 2'd3, 1'b1);

        // Idle keeps pointer at 1
        bus.hold = 4'b0000;
        bus.req  = 4'b0010;
        step();
        check("idle_setup", 32'(bus.grant), 32'h2);
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant("idle", 4'b0000, 2'd0, 1'b0);
        end
        bus.req = 4'b1111;
        step();
        check_grant("idle_resume", 4'b0100, 2'd2, 1'b1);

        // Requester 3 starts a held tenure, then reset lands mid-tenure
        bus.hold = 4'b1000;
        step();
        check("rst_hold_a", 32'(bus.grant), 32'h8);
        step();
        check("rst_hold_b", 32'(bus.grant), 32'h8);
        rst = 1'b1;
        step();
        check_grant("mid_rst", 4'b0000, 2'd0, 1'b0);
        rst      = 1'b0;
        bus.hold = 4'b0000;
        step();
        check_grant("post_rst", 4'b0001, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
